ws2812b_rx: RTL and testbench
=============================

# ws2812b_rx

Decoder for the WS2812B NZR single-wire protocol, the receiving end of the LED-strip transmit path. It samples a serial data line, classifies each high pulse as a 0 or 1 bit, and assembles 24-bit GRB words, MSB first. It detects the >280 µs reset gap that ends a frame, and forwards the stream downstream once its own word is consumed, like a strip pixel. It is used as an on-board loopback monitor for the transmit path and as a pixel model in benches.

## Interface
- CLK_HZ, 50_000_000: clock frequency; all cycle constants below assume this value.
- MIN_HIGH, 5: high pulses shorter than this many cycles are glitches.
- BIT_THRESH, 30: a high width of at least this many cycles (0.6 µs) decodes as 1; shorter decodes as 0.
- MAX_HIGH, 100: a high width of at least this many cycles (2 µs) is a protocol error.
- RESET_CYC, 14000: low cycles (280 µs) that mark end of frame.

- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high.
- din  in  1  raw NZR line, asynchronous to clk.
- dout  out  1  pass-through line for the next node.
- grb  out  24  last decoded word, {G,R,B}, MSB first.
- grb_valid  out  1  one-cycle strobe; grb and led_index are new.
- led_index  out  8  0-based position of the grb word in the current frame.
- own_grb  out  24  word at index 0 of the last frame; held between frames.
- frame_done  out  1  one-cycle strobe at the end-of-frame gap.
- led_count  out  8  number of complete words in the finished frame; valid with frame_done.
- err  out  1  one-cycle strobe on glitch, overlong high, or partial word at frame end.

## Operation
- din passes through a 2-flop synchronizer to give din_s. All decisions use din_s.
- States:
  - SYNC waits for RESET_CYC consecutive low cycles. It is entered on reset and after an overlong high.
  - IDLE waits for a high.
  - HIGH counts the high width in hcnt.
  - LOW counts the low width in lcnt.
- Transitions:
  - SYNC→IDLE when lcnt reaches RESET_CYC.
  - IDLE→HIGH when din_s=1; hcnt is cleared.
  - HIGH→SYNC with an err strobe when hcnt reaches MAX_HIGH.
  - HIGH→LOW when din_s=0. At this point:
    - if hcnt<MIN_HIGH: err strobe, bit discarded;
    - otherwise shift in bit (hcnt>=BIT_THRESH) and increment bitcnt.
  - LOW→HIGH when din_s=1.
  - LOW→IDLE when lcnt reaches RESET_CYC. This is end of frame.
- Word completion (bitcnt reaches 24):
  - grb gets the shift register; grb_valid strobes; led_index gets wcnt.
  - If wcnt=0, own_grb is loaded and pass_en is set.
  - wcnt increments, saturating at 255; bitcnt clears.
- End of frame:
  - frame_done strobes with led_count=wcnt.
  - If bitcnt≠0, err also strobes in the same cycle and the partial word is dropped.
  - wcnt, bitcnt and pass_en clear.
- dout = din_s AND pass_en. The pulse that completes word 0 is not forwarded; the first forwarded edge belongs to word 1.
- hcnt and lcnt are 16-bit and saturate. Neither counter wraps.

## Timing
- Reset values: dout=0, grb=0, grb_valid=0, led_index=0, own_grb=0, frame_done=0, led_count=0, err=0. State is SYNC.
- Strobe latency:
  - Let cycle N be the first cycle din_s=0 after the 24th high pulse. grb_valid is high in cycle N+1 only.
  - frame_done is high in the cycle after lcnt reaches RESET_CYC.
- Raw din to din_s is 2 cycles. dout lags din by 2 cycles.
- Simultaneous events cannot occur: grb_valid and frame_done are never high in the same cycle, because a word completes on a falling edge and a frame ends ≥RESET_CYC later.
- Reset asserted mid-word or mid-frame: everything returns to the reset state immediately. Decoding resumes only after a full RESET_CYC low.

## Structure
- Shared package ws2812b_pkg holds:
  - the state enum {SYNC, IDLE, HIGH, LOW};
  - the default timing constants;
  - GRB_BITS=24.
- The transmit-side generator uses the same timing constants.
- One sub-module, nzr_pulse_meter: synchronizer plus hcnt/lcnt. It outputs a fall strobe with the measured width and a gap strobe.
- Word assembly, word counting and pass-through live in ws2812b_rx.

## Test plan
- Power-up, 300 µs low, then 24 bits of 0xFF0000 at 0.8/0.45 µs timing, then a 300 µs gap → grb_valid once with grb=0xFF0000, led_index=0, own_grb=0xFF0000; frame_done with led_count=1; err never.
- Five words 0x00FF00, 0x0000FF, 0x123456, 0xA5A5A5, 0x000001 → five grb_valid strobes with led_index 0..4; led_count=5; dout carries exactly the last 96 pulses, delayed 2 cycles.
- 3-cycle high spike mid-word, followed by valid bits → err strobe; the bit is not counted; the following 24 valid bits still decode correctly.
- 10 valid bits, then a 300 µs gap → frame_done with led_count=0 and err in the same cycle; no grb_valid.
- A 3 µs high pulse → err; the decoder ignores pulses until 280 µs of low, then decodes 0x0F0F0F correctly.
- Reset asserted at bit 12 of word 2 → all outputs 0 the next cycle; a following clean frame decodes correctly.

Source files
------------

// File: rtl/ws2812b_pkg.sv
// Shared WS2812B NZR timing constants and decoder state encoding.
// Used by the receive decoder here and by the transmit-side generator.
package ws2812b_pkg;

    typedef logic [1:0] state_t;
    localparam state_t SYNC = 2'd0;
    localparam state_t IDLE = 2'd1;
    localparam state_t HIGH = 2'd2;
    localparam state_t LOW  = 2'd3;

    localparam int GRB_BITS = 24;
    localparam int CNT_W    = 16;

    localparam int DEF_CLK_HZ      = 50_000_000;
    localparam int T_MIN_HIGH_NS   = 100;
    localparam int T_BIT_THRESH_NS = 600;
    localparam int T_MAX_HIGH_NS   = 2_000;
    localparam int T_RESET_NS      = 280_000;

    // 64-bit intermediate: clk_hz * 280 us overflows a 32-bit int.
    function automatic int ns_to_cyc(input int clk_hz, input int ns);
        return int'(longint'(clk_hz) * longint'(ns) / longint'(1_000_000_000));
    endfunction

    localparam int DEF_MIN_HIGH   = ns_to_cyc(DEF_CLK_HZ, T_MIN_HIGH_NS);
    localparam int DEF_BIT_THRESH = ns_to_cyc(DEF_CLK_HZ, T_BIT_THRESH_NS);
    localparam int DEF_MAX_HIGH   = ns_to_cyc(DEF_CLK_HZ, T_MAX_HIGH_NS);
    localparam int DEF_RESET_CYC  = ns_to_cyc(DEF_CLK_HZ, T_RESET_NS);

endpackage

// File: rtl/nzr_pulse_meter.sv
// Synchronizes the NZR line and measures high/low run lengths.
// Latency: din to din_s 2 cycles; fall/gap strobes are combinational off the counters.
// Backpressure: none, the line cannot be stalled; strobes must be consumed as they occur.
module nzr_pulse_meter
    import ws2812b_pkg::*;
#(
    parameter int MAX_HIGH  = DEF_MAX_HIGH,
    parameter int RESET_CYC = DEF_RESET_CYC
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             din,
    output logic             din_s,
    output logic             fall,
    output logic [CNT_W-1:0] hwidth,
    output logic             long_high,
    output logic             gap
);

    localparam logic [CNT_W-1:0] MAX_W = CNT_W'(MAX_HIGH);
    localparam logic [CNT_W-1:0] GAP_W = CNT_W'(RESET_CYC);
    localparam logic [CNT_W-1:0] SAT   = '1;

    logic             sync1;
    logic [CNT_W-1:0] hcnt;
    logic [CNT_W-1:0] lcnt;

    // Each counter holds the run length seen so far and is cleared by the
    // opposite level, so hcnt still holds the full width in the first low cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b0;
            din_s <= 1'b0;
            hcnt  <= '0;
            lcnt  <= '0;
        end else begin
            sync1 <= din;
            din_s <= sync1;
            if (din_s) begin
                hcnt <= (hcnt == SAT) ? hcnt : hcnt + 1'b1;
                lcnt <= '0;
            end else begin
                hcnt <= '0;
                lcnt <= (lcnt == SAT) ? lcnt : lcnt + 1'b1;
            end
        end
    end

    assign fall      = !din_s && (hcnt != '0);
    assign hwidth    = hcnt;
    assign long_high = (hcnt == MAX_W);
    assign gap       = (lcnt == GAP_W);

endmodule

// File: rtl/ws2812b_rx.sv
// WS2812B NZR receiver: decodes 24-bit GRB words, detects frame gaps, forwards like a pixel.
// Latency: grb_valid one cycle after din_s falls on the 24th bit; dout lags din by 2 cycles.
// Backpressure: none; strobes are single-cycle and must be captured when they fire.
module ws2812b_rx
    import ws2812b_pkg::*;
#(
    parameter int CLK_HZ     = DEF_CLK_HZ,
    parameter int MIN_HIGH   = ns_to_cyc(CLK_HZ, T_MIN_HIGH_NS),
    parameter int BIT_THRESH = ns_to_cyc(CLK_HZ, T_BIT_THRESH_NS),
    parameter int MAX_HIGH   = ns_to_cyc(CLK_HZ, T_MAX_HIGH_NS),
    parameter int RESET_CYC  = ns_to_cyc(CLK_HZ, T_RESET_NS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                din,
    output logic                dout,
    output logic [GRB_BITS-1:0] grb,
    output logic                grb_valid,
    output logic [7:0]          led_index,
    output logic [GRB_BITS-1:0] own_grb,
    output logic                frame_done,
    output logic [7:0]          led_count,
    output logic                err
);

    localparam logic [CNT_W-1:0] MIN_W    = CNT_W'(MIN_HIGH);
    localparam logic [CNT_W-1:0] BIT_W    = CNT_W'(BIT_THRESH);
    localparam logic [4:0]       LAST_BIT = 5'(GRB_BITS - 1);

    logic             din_s;
    logic             fall;
    logic             long_high;
    logic             gap;
    logic [CNT_W-1:0] hwidth;

    state_t              state;
    logic [GRB_BITS-2:0] sr;
    logic [4:0]          bitcnt;
    logic [7:0]          wcnt;
    logic                pass_en;
    logic                bit_val;

    nzr_pulse_meter #(
        .MAX_HIGH  (MAX_HIGH),
        .RESET_CYC (RESET_CYC)
    ) u_meter (
        .clk       (clk),
        .reset     (reset),
        .din       (din),
        .din_s     (din_s),
        .fall      (fall),
        .hwidth    (hwidth),
        .long_high (long_high),
        .gap       (gap)
    );

    assign bit_val = (hwidth >= BIT_W);
    assign dout    = din_s & pass_en;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= SYNC;
            sr         <= '0;
            bitcnt     <= '0;
            wcnt       <= '0;
            pass_en    <= 1'b0;
            grb        <= '0;
            grb_valid  <= 1'b0;
            led_index  <= '0;
            own_grb    <= '0;
            frame_done <= 1'b0;
            led_count  <= '0;
            err        <= 1'b0;
        end else begin
            grb_valid  <= 1'b0;
            frame_done <= 1'b0;
            err        <= 1'b0;
            case (state)
                SYNC: if (gap) state <= IDLE;
                IDLE: if (din_s) state <= HIGH;
                HIGH: begin
                    // An overlong high aborts the frame; resync before trusting the line again.
                    if (long_high) begin
                        state   <= SYNC;
                        err     <= 1'b1;
                        bitcnt  <= '0;
                        wcnt    <= '0;
                        pass_en <= 1'b0;
                    end else if (fall) begin
                        state <= LOW;
                        if (hwidth < MIN_W) begin
                            err <= 1'b1;
                        end else begin
                            sr <= {sr[GRB_BITS-3:0], bit_val};
                            if (bitcnt == LAST_BIT) begin
                                grb       <= {sr, bit_val};
                                grb_valid <= 1'b1;
                                led_index <= wcnt;
                                bitcnt    <= '0;
                                wcnt      <= (wcnt == 8'hFF) ? wcnt : wcnt + 8'd1;
                                if (wcnt == 8'd0) begin
                                    own_grb <= {sr, bit_val};
                                    pass_en <= 1'b1;
                                end
                            end else begin
                                bitcnt <= bitcnt + 5'd1;
                            end
                        end
                    end
                end
                LOW: begin
                    if (gap) begin
                        state      <= IDLE;
                        frame_done <= 1'b1;
                        led_count  <= wcnt;
                        err        <= (bitcnt != '0);
                        bitcnt     <= '0;
                        wcnt       <= '0;
                        pass_en    <= 1'b0;
                    end else if (din_s) begin
                        state <= HIGH;
                    end
                end
                default: state <= SYNC;
            endcase
        end
    end

endmodule

// File: tb/tb_ws2812b_rx.sv
// Directed bench for ws2812b_rx; the frame gap is shortened to keep runs brief.
module tb_ws2812b_rx;

    localparam int RST = 2000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        din = 1'b0;
    logic        dout, grb_valid, frame_done, err;
    logic [23:0] grb, own_grb;
    logic [7:0]  led_index, led_count;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int last_fall = 0;

    logic        p1 = 1'b0, p2 = 1'b0, dout_q = 1'b0;
    logic [23:0] gv_grb[$];
    logic [7:0]  gv_idx[$];
    int          gv_cyc[$];
    int          fd_cnt = 0, fd_cyc = 0, err_cnt = 0, both_cnt = 0;
    int          dout_rise = 0, dout_hi = 0, dout_bad = 0;
    logic [7:0]  fd_count = 8'd0;
    logic        fd_err = 1'b0;

    always #10 clk = ~clk;

    ws2812b_rx #(.RESET_CYC(RST)) dut (
        .clk        (clk),
        .reset      (reset),
        .din        (din),
        .dout       (dout),
        .grb        (grb),
        .grb_valid  (grb_valid),
        .led_index  (led_index),
        .own_grb    (own_grb),
        .frame_done (frame_done),
        .led_count  (led_count),
        .err        (err)
    );

    // p2 mirrors the DUT's synchronized line so dout can be checked against it.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        p1  <= din;
        p2  <= p1;
    end

    always @(negedge clk) begin
        dout_q <= dout;
        if (grb_valid) begin
            gv_grb.push_back(grb);
            gv_idx.push_back(led_index);
            gv_cyc.push_back(cyc);
        end
        if (frame_done) begin
            fd_cnt   <= fd_cnt + 1;
            fd_cyc   <= cyc;
            fd_count <= led_count;
            fd_err   <= err;
        end
        if (err) err_cnt <= err_cnt + 1;
        if (grb_valid && frame_done) both_cnt <= both_cnt + 1;
        if (dout && !dout_q) dout_rise <= dout_rise + 1;
        if (dout) dout_hi <= dout_hi + 1;
        if (dout && !p2) dout_bad <= dout_bad + 1;
    end

    task automatic hold(input logic v, input int n);
        din = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_pulse(input int hi, input int lo);
        hold(1'b1, hi);
        last_fall = cyc;
        hold(1'b0, lo);
    endtask

    task automatic send_bits(input logic [23:0] w, input int msb, input int lsb);
        for (int i = msb; i >= lsb; i--) begin
            if (w[i]) send_pulse(40, 22);
            else      send_pulse(20, 42);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        n_checks++; if (dout !== 1'b0) begin n_fail++; $display("FAIL %s_dout: got %b expected 0", tag, dout); end
        n_checks++; if (grb !== 24'h0) begin n_fail++; $display("FAIL %s_grb: got %h expected 000000", tag, grb); end
        n_checks++; if (grb_valid !== 1'b0) begin n_fail++; $display("FAIL %s_grb_valid: got %b expected 0", tag, grb_valid); end
        n_checks++; if (led_index !== 8'h0) begin n_fail++; $display("FAIL %s_led_index: got %0d expected 0", tag, led_index); end
        n_checks++; if (own_grb !== 24'h0) begin n_fail++; $display("FAIL %s_own_grb: got %h expected 000000", tag, own_grb); end
        n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL %s_frame_done: got %b expected 0", tag, frame_done); end
        n_checks++; if (led_count !== 8'h0) begin n_fail++; $display("FAIL %s_led_count: got %0d expected 0", tag, led_count); end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL %s_err: got %b expected 0", tag, err); end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        reset = 1'b0;
        hold(1'b0, RST + 100);
    endtask

    task automatic test_single();
        int g0, f0, e0, lf, gc;
        logic [23:0] gg;
        logic [7:0]  gi;
        g0 = gv_grb.size(); f0 = fd_cnt; e0 = err_cnt;
        send_bits(24'hFF0000, 23, 0);
        lf = last_fall;
        hold(1'b0, RST + 100);
        gg = (gv_grb.size() > g0) ? gv_grb[g0] : 24'hx;
        gi = (gv_idx.size() > g0) ? gv_idx[g0] : 8'hx;
        gc = (gv_cyc.size() > g0) ? gv_cyc[g0] : -1;
        n_checks++; if (gv_grb.size() - g0 != 1) begin n_fail++; $display("FAIL single_gv_count: got %0d expected 1", gv_grb.size() - g0); end
        n_checks++; if (gg !== 24'hFF0000) begin n_fail++; $display("FAIL single_grb: got %h expected ff0000", gg); end
        n_checks++; if (gi !== 8'd0) begin n_fail++; $display("FAIL single_led_index: got %0d expected 0", gi); end
        n_checks++; if (gc != lf + 3) begin n_fail++; $display("FAIL single_gv_latency: got cycle %0d expected %0d", gc, lf + 3); end
        n_checks++; if (own_grb !== 24'hFF0000) begin n_fail++; $display("FAIL single_own_grb: got %h expected ff0000", own_grb); end
        n_checks++; if (fd_cnt - f0 != 1) begin n_fail++; $display("FAIL single_fd_count: got %0d expected 1", fd_cnt - f0); end
        n_checks++; if (fd_count !== 8'd1) begin n_fail++; $display("FAIL single_led_count: got %0d expected 1", fd_count); end
        n_checks++; if (fd_cyc != lf + 3 + RST) begin n_fail++; $display("FAIL single_fd_latency: got cycle %0d expected %0d", fd_cyc, lf + 3 + RST); end
        n_checks++; if (err_cnt - e0 != 0) begin n_fail++; $display("FAIL single_err: got %0d strobes expected 0", err_cnt - e0); end
    endtask

    task automatic test_multi();
        logic [23:0] words [5] = '{24'h00FF00, 24'h0000FF, 24'h123456, 24'hA5A5A5, 24'h000001};
        int g0, f0, e0, r0, h0, b0;
        g0 = gv_grb.size(); f0 = fd_cnt; e0 = err_cnt;
        r0 = dout_rise; h0 = dout_hi; b0 = dout_bad;
        send_bits(words[0], 23, 0);
        hold(1'b0, RST - 1 - 42);
        for (int w = 1; w < 5; w++) send_bits(words[w], 23, 0);
        hold(1'b0, RST + 100);
        n_checks++; if (gv_grb.size() - g0 != 5) begin n_fail++; $display("FAIL multi_gv_count: got %0d expected 5", gv_grb.size() - g0); end
        for (int w = 0; w < 5; w++) begin
            logic [23:0] gg;
            logic [7:0]  gi;
            gg = (gv_grb.size() > g0 + w) ? gv_grb[g0 + w] : 24'hx;
            gi = (gv_idx.size() > g0 + w) ? gv_idx[g0 + w] : 8'hx;
            n_checks++; if (gg !== words[w]) begin n_fail++; $display("FAIL multi_grb%0d: got %h expected %h", w, gg, words[w]); end
            n_checks++; if (gi !== 8'(w)) begin n_fail++; $display("FAIL multi_idx%0d: got %0d expected %0d", w, gi, w); end
        end
        n_checks++; if (fd_cnt - f0 != 1) begin n_fail++; $display("FAIL multi_fd_count: got %0d expected 1", fd_cnt - f0); end
        n_checks++; if (fd_count !== 8'd5) begin n_fail++; $display("FAIL multi_led_count: got %0d expected 5", fd_count); end
        n_checks++; if (own_grb !== 24'h00FF00) begin n_fail++; $display("FAIL multi_own_grb: got %h expected 00ff00", own_grb); end
        n_checks++; if (err_cnt - e0 != 0) begin n_fail++; $display("FAIL multi_err: got %0d strobes expected 0", err_cnt - e0); end
        // Words 1..4 hold 30 ones (40 cycles high) and 66 zeros (20 cycles high).
        n_checks++; if (dout_rise - r0 != 96) begin n_fail++; $display("FAIL multi_dout_pulses: got %0d expected 96", dout_rise - r0); end
        n_checks++; if (dout_hi - h0 != 2520) begin n_fail++; $display("FAIL multi_dout_high: got %0d expected 2520", dout_hi - h0); end
        n_checks++; if (dout_bad - b0 != 0) begin n_fail++; $display("FAIL multi_dout_align: got %0d misaligned expected 0", dout_bad - b0); end
    endtask

    task automatic test_glitch();
        int g0, f0, e0;
        logic [23:0] gg;
        g0 = gv_grb.size(); f0 = fd_cnt; e0 = err_cnt;
        send_bits(24'h5A3C96, 23, 12);
        send_pulse(3, 30);
        send_bits(24'h5A3C96, 11, 0);
        hold(1'b0, RST + 100);
        gg = (gv_grb.size() > g0) ? gv_grb[g0] : 24'hx;
        n_checks++; if (gv_grb.size() - g0 != 1) begin n_fail++; $display("FAIL glitch_gv_count: got %0d expected 1", gv_grb.size() - g0); end
        n_checks++; if (gg !== 24'h5A3C96) begin n_fail++; $display("FAIL glitch_grb: got %h expected 5a3c96", gg); end
        n_checks++; if (err_cnt - e0 != 1) begin n_fail++; $display("FAIL glitch_err: got %0d strobes expected 1", err_cnt - e0); end
        n_checks++; if (fd_count !== 8'd1) begin n_fail++; $display("FAIL glitch_led_count: got %0d expected 1", fd_count); end
        n_checks++; if (fd_err !== 1'b0) begin n_fail++; $display("FAIL glitch_fd_err: got %b expected 0", fd_err); end
    endtask

    task automatic test_thresholds();
        logic [23:0] w = 24'h3C3C3C;
        logic [23:0] gg;
        int g0, e0, hi;
        g0 = gv_grb.size(); e0 = err_cnt;
        send_pulse(4, 30);
        for (int i = 23; i >= 0; i--) begin
            if (w[i]) hi = (i % 2 == 1) ? 30 : 99;
            else      hi = (i % 2 == 1) ? 5 : 29;
            send_pulse(hi, 30);
        end
        hold(1'b0, RST + 100);
        gg = (gv_grb.size() > g0) ? gv_grb[g0] : 24'hx;
        n_checks++; if (gg !== 24'h3C3C3C) begin n_fail++; $display("FAIL thresh_grb: got %h expected 3c3c3c", gg); end
        n_checks++; if (err_cnt - e0 != 1) begin n_fail++; $display("FAIL thresh_err: got %0d strobes expected 1", err_cnt - e0); end
        n_checks++; if (own_grb !== 24'h3C3C3C) begin n_fail++; $display("FAIL thresh_own_grb: got %h expected 3c3c3c", own_grb); end
    endtask

    task automatic test_partial();
        int g0, f0, e0;
        g0 = gv_grb.size(); f0 = fd_cnt; e0 = err_cnt;
        send_bits(24'hFFFFFF, 23, 14);
        hold(1'b0, RST + 100);
        n_checks++; if (gv_grb.size() - g0 != 0) begin n_fail++; $display("FAIL partial_gv_count: got %0d expected 0", gv_grb.size() - g0); end
        n_checks++; if (fd_cnt - f0 != 1) begin n_fail++; $display("FAIL partial_fd_count: got %0d expected 1", fd_cnt - f0); end
        n_checks++; if (fd_count !== 8'd0) begin n_fail++; $display("FAIL partial_led_count: got %0d expected 0", fd_count); end
        n_checks++; if (fd_err !== 1'b1) begin n_fail++; $display("FAIL partial_fd_err: got %b expected 1", fd_err); end
        n_checks++; if (err_cnt - e0 != 1) begin n_fail++; $display("FAIL partial_err: got %0d strobes expected 1", err_cnt - e0); end
    endtask

    task automatic test_overlong();
        int g0, f0, e0;
        logic [23:0] gg;
        logic [7:0]  gi;
        g0 = gv_grb.size(); f0 = fd_cnt; e0 = err_cnt;
        hold(1'b1, 150);
        hold(1'b0, 50);
        send_bits(24'hFFFFFF, 23, 0);
        hold(1'b0, RST + 50);
        hold(1'b1, 100);
        hold(1'b0, RST + 50);
        send_bits(24'h0F0F0F, 23, 0);
        hold(1'b0, RST + 100);
        gg = (gv_grb.size() > g0) ? gv_grb[g0] : 24'hx;
        gi = (gv_idx.size() > g0) ? gv_idx[g0] : 8'hx;
        n_checks++; if (err_cnt - e0 != 2) begin n_fail++; $display("FAIL overlong_err: got %0d strobes expected 2", err_cnt - e0); end
        n_checks++; if (gv_grb.size() - g0 != 1) begin n_fail++; $display("FAIL overlong_gv_count: got %0d expected 1", gv_grb.size() - g0); end
        n_checks++; if (gg !== 24'h0F0F0F) begin n_fail++; $display("FAIL overlong_grb: got %h expected 0f0f0f", gg); end
        n_checks++; if (gi !== 8'd0) begin n_fail++; $display("FAIL overlong_idx: got %0d expected 0", gi); end
        n_checks++; if (fd_cnt - f0 != 1) begin n_fail++; $display("FAIL overlong_fd_count: got %0d expected 1", fd_cnt - f0); end
        n_checks++; if (fd_count !== 8'd1) begin n_fail++; $display("FAIL overlong_led_count: got %0d expected 1", fd_count); end
    endtask

    task automatic test_reset_mid();
        int g0, f0, e0;
        logic [23:0] gg;
        logic [7:0]  gi;
        g0 = gv_grb.size(); f0 = fd_cnt; e0 = err_cnt;
        send_bits(24'h111111, 23, 0);
        send_bits(24'h222222, 23, 0);
        send_bits(24'h333333, 23, 12);
        hold(1'b1, 10);
        reset = 1'b1;
        din = 1'b0;
        @(posedge clk);
        #1;
        check_outputs_zero("midreset");
        n_checks++; if (gv_grb.size() - g0 != 2) begin n_fail++; $display("FAIL midreset_gv_before: got %0d expected 2", gv_grb.size() - g0); end
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        send_bits(24'hE00000, 23, 21);
        hold(1'b0, RST + 50);
        send_bits(24'hC0FFEE, 23, 0);
        hold(1'b0, RST + 100);
        gg = (gv_grb.size() > g0 + 2) ? gv_grb[g0 + 2] : 24'hx;
        gi = (gv_idx.size() > g0 + 2) ? gv_idx[g0 + 2] : 8'hx;
        n_checks++; if (gv_grb.size() - g0 != 3) begin n_fail++; $display("FAIL midreset_gv_count: got %0d expected 3", gv_grb.size() - g0); end
        n_checks++; if (gg !== 24'hC0FFEE) begin n_fail++; $display("FAIL midreset_grb: got %h expected c0ffee", gg); end
        n_checks++; if (gi !== 8'd0) begin n_fail++; $display("FAIL midreset_idx: got %0d expected 0", gi); end
        n_checks++; if (own_grb !== 24'hC0FFEE) begin n_fail++; $display("FAIL midreset_own_grb: got %h expected c0ffee", own_grb); end
        n_checks++; if (fd_cnt - f0 != 1) begin n_fail++; $display("FAIL midreset_fd_count: got %0d expected 1", fd_cnt - f0); end
        n_checks++; if (fd_count !== 8'd1) begin n_fail++; $display("FAIL midreset_led_count: got %0d expected 1", fd_count); end
        n_checks++; if (err_cnt - e0 != 0) begin n_fail++; $display("FAIL midreset_err: got %0d strobes expected 0", err_cnt - e0); end
    endtask

    task automatic test_exclusive();
        n_checks++; if (both_cnt != 0) begin n_fail++; $display("FAIL strobe_overlap: got %0d cycles expected 0", both_cnt); end
    endtask

    initial begin
        @(posedge clk);
        #1;
        test_reset();
        test_single();
        test_multi();
        test_glitch();
        test_thresholds();
        test_partial();
        test_overlong();
        test_reset_mid();
        test_exclusive();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
